// File: rtl/ram_rd_axis_streamer.sv
// Streams a contiguous block of RAM words out on AXI4-Stream.
// A read is issued only while there is room for its data. The stream is fed from a 2-entry FIFO, or straight from the RAM when the FIFO is empty.
module ram_rd_axis_streamer #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  xfer_len,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t                         state, state_nxt;
  logic [ADDR_WIDTH-1:0]          addr;
  logic [LEN_WIDTH-1:0]           rd_left, beat_left;
  logic                           rd_vld;
  logic [1:0][DATA_WIDTH-1:0]     fifo;
  logic                           wr_ptr, rd_ptr;
  logic [1:0]                     count;
  logic                           fire, push, pop, beat_last, fifo_empty;
  logic [DATA_WIDTH-1:0]          head;

  assign fifo_empty    = (count == 2'd0);
  // Buffered words plus the read in flight must stay below the FIFO depth.
  assign ram_en        = (state == S_READ) && ((count + {1'b0, rd_vld}) < 2'd2);
  assign ram_addr      = addr;
  assign busy          = (state != S_IDLE);

  // With an empty FIFO the arriving RAM word is presented directly.
  assign head          = fifo_empty ? ram_rdata : fifo[rd_ptr];
  assign m_axis_tvalid = !fifo_empty || rd_vld;
  assign m_axis_tdata  = m_axis_tvalid ? head : '0;
  assign beat_last     = (beat_left == LEN_WIDTH'(1));
  assign m_axis_tlast  = m_axis_tvalid && beat_last;

  assign fire = m_axis_tvalid && m_axis_tready;
  assign pop  = fire && !fifo_empty;
  // An arriving word is stored unless it leaves as a bypassed beat in this cycle.
  assign push = rd_vld && !(fifo_empty && m_axis_tready);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start && xfer_len != '0)         state_nxt = S_READ;
      S_READ:  if (ram_en && rd_left == LEN_WIDTH'(1)) state_nxt = S_DRAIN;
      S_DRAIN: if (fire && beat_last)               state_nxt = S_IDLE;
      default:                                      state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      addr      <= '0;
      rd_left   <= '0;
      beat_left <= '0;
      rd_vld    <= 1'b0;
      done      <= 1'b0;
      fifo      <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      rd_vld <= ram_en;
      done   <= ((state == S_IDLE) && start && (xfer_len == '0)) ||
                ((state == S_DRAIN) && fire && beat_last);
      if (state == S_IDLE) begin
        if (start) begin
          addr      <= base_addr;
          rd_left   <= xfer_len;
          beat_left <= xfer_len;
        end
      end else begin
        if (ram_en) begin
          addr    <= addr + ADDR_WIDTH'(1);
          rd_left <= rd_left - LEN_WIDTH'(1);
        end
        if (fire) beat_left <= beat_left - LEN_WIDTH'(1);
      end
      if (push) begin
        fifo[wr_ptr] <= ram_rdata;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_rd_axis_streamer.sv
// Directed bench for ram_rd_axis_streamer with a behavioural 1-cycle RAM.
module tb_ram_rd_axis_streamer;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] xfer_len = '0;
  logic        busy, done, ram_en;
  logic [9:0]  ram_addr;
  logic [31:0] ram_rdata = '0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;

  ram_rd_axis_streamer #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .LEN_WIDTH(11)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .base_addr(base_addr),
    .xfer_len(xfer_len), .busy(busy), .done(done), .ram_en(ram_en),
    .ram_addr(ram_addr), .ram_rdata(ram_rdata), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast)
  );

  always #5 ACLK = ~ACLK;

  logic [31:0] mem [1024];
  always @(posedge ACLK) if (ram_en) ram_rdata <= mem[ram_addr];

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  logic tog = 1'b0;
  always begin
    @(posedge ACLK);
    #1;
    if (tog) m_axis_tready = ~m_axis_tready;
  end

  // Transfer log, sampled on the falling edge.
  logic [31:0] beat_d [$];
  logic        beat_l [$];
  int          beat_c [$];
  logic [9:0]  en_addr [$];
  int issued, accepted, max_out, first_vld, done_n, done_cyc, stall_err, start_cyc;
  logic        prev_stall;
  logic [31:0] prev_data;
  logic        prev_last;

  always @(negedge ACLK) begin
    if (!ARESETN) prev_stall = 1'b0;
    else begin
      if (ram_en) begin
        en_addr.push_back(ram_addr);
        issued++;
        if (issued - accepted > max_out) max_out = issued - accepted;
      end
      if (m_axis_tvalid && first_vld < 0) first_vld = cyc;
      if (prev_stall && !(m_axis_tvalid && m_axis_tdata == prev_data && m_axis_tlast == prev_last))
        stall_err++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        beat_d.push_back(m_axis_tdata);
        beat_l.push_back(m_axis_tlast);
        beat_c.push_back(cyc);
        accepted++;
      end
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    beat_d.delete(); beat_l.delete(); beat_c.delete(); en_addr.delete();
    issued = 0; accepted = 0; max_out = 0; first_vld = -1;
    done_n = 0; done_cyc = -1; stall_err = 0; prev_stall = 1'b0;
  endtask

  task automatic do_start(input logic [9:0] b, input logic [10:0] l);
    @(posedge ACLK); #1;
    start = 1'b1; base_addr = b; xfer_len = l; start_cyc = cyc;
    @(posedge ACLK); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_n == 0 && n < 300) begin
      @(posedge ACLK); n++;
    end
    chk({tag, "_done_seen"}, 32'(done_n != 0), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic chk_data(input string tag, input logic [9:0] b, input int len);
    logic [15:0] lm;
    lm = '0;
    chk({tag, "_beats"}, 32'(beat_d.size()), 32'(len));
    for (int i = 0; i < len && i < beat_d.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), beat_d[i], mem[10'(b + 10'(i))]);
      lm[i] = beat_l[i];
    end
    chk({tag, "_tlast_mask"}, 32'(lm), 32'(1) << (len - 1));
  endtask

  initial begin
    int n, held;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
    clr();
    idle(2);
    chk("reset_outputs", {busy, done, ram_en, ram_addr, m_axis_tdata, m_axis_tvalid, m_axis_tlast}, '0);
    ARESETN = 1'b1;
    idle(2);

    // T1 basic
    for (int i = 0; i < 4; i++) mem[i] = 32'(i + 1);
    clr();
    do_start(10'h000, 11'd4);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done("t1");
    idle(3);
    chk_data("t1", 10'h000, 4);
    chk("t1_consecutive", 32'(beat_c[3] - beat_c[0]), 32'd3);
    chk("t1_first_en_lat", 32'(issued > 0 ? 1 : 0), 32'd1);
    chk("t1_first_vld_lat", 32'(first_vld - start_cyc), 32'd2);
    chk("t1_done_lat", 32'(done_cyc - beat_c[3]), 32'd1);
    chk("t1_done_count", 32'(done_n), 32'd1);
    chk("t1_busy_after", 32'(busy), 32'd0);

    // T2 backpressure, tready toggling 1010...
    for (int i = 0; i < 8; i++) mem[10'h100 + i] = 32'h10 + 32'(i);
    clr();
    m_axis_tready = 1'b1;
    tog = 1'b1;
    do_start(10'h100, 11'd8);
    wait_done("t2");
    tog = 1'b0;
    m_axis_tready = 1'b1;
    idle(3);
    chk_data("t2", 10'h100, 8);
    chk("t2_stable", 32'(stall_err), 32'd0);
    chk("t2_outstanding", 32'(max_out <= 2), 32'd1);
    chk("t2_reads", 32'(issued), 32'd8);

    // T3 address wrap
    mem[10'h3FE] = 32'hA0; mem[10'h3FF] = 32'hA1; mem[10'h000] = 32'hA2; mem[10'h001] = 32'hA3;
    clr();
    do_start(10'h3FE, 11'd4);
    wait_done("t3");
    idle(3);
    chk("t3_naddr", 32'(en_addr.size()), 32'd4);
    if (en_addr.size() == 4) begin
      chk("t3_addr0", 32'(en_addr[0]), 32'h3FE);
      chk("t3_addr1", 32'(en_addr[1]), 32'h3FF);
      chk("t3_addr2", 32'(en_addr[2]), 32'h000);
      chk("t3_addr3", 32'(en_addr[3]), 32'h001);
    end
    chk_data("t3", 10'h3FE, 4);

    // T4 zero length, then a start ignored mid-transfer
    clr();
    do_start(10'h010, 11'd0);
    wait_done("t4z");
    idle(3);
    chk("t4z_done_lat", 32'(done_cyc - start_cyc), 32'd1);
    chk("t4z_no_valid", 32'(first_vld < 0), 32'd1);
    chk("t4z_no_en", 32'(issued), 32'd0);
    chk("t4z_done_count", 32'(done_n), 32'd1);
    for (int i = 0; i < 6; i++) mem[10'h200 + i] = 32'hB00 + 32'(i);
    clr();
    do_start(10'h200, 11'd6);
    idle(1);
    start = 1'b1; base_addr = 10'h000; xfer_len = 11'd5;
    idle(1);
    start = 1'b0;
    wait_done("t4");
    idle(10);
    chk_data("t4", 10'h200, 6);
    chk("t4_done_count", 32'(done_n), 32'd1);
    chk("t4_reads", 32'(issued), 32'd6);

    // T5 reset abort after beat 3
    clr();
    do_start(10'h300, 11'd16);
    n = 0;
    while (beat_d.size() < 3 && n < 100) begin
      @(posedge ACLK); n++;
    end
    #1;
    chk("t5_reached_beat3", 32'(beat_d.size()), 32'd3);
    ARESETN = 1'b0;
    #1;
    chk("t5_reset_outputs", {busy, done, ram_en, ram_addr, m_axis_tdata, m_axis_tvalid, m_axis_tlast}, '0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    idle(5);
    chk("t5_no_more_beats", 32'(beat_d.size()), 32'd3);
    chk("t5_no_done", 32'(done_n), 32'd0);
    mem[0] = 32'h55; mem[1] = 32'h66;
    clr();
    do_start(10'h000, 11'd2);
    wait_done("t5b");
    idle(3);
    chk_data("t5b", 10'h000, 2);

    // T6 single beat stalled at the end
    mem[10'h050] = 32'h77;
    clr();
    m_axis_tready = 1'b0;
    do_start(10'h050, 11'd1);
    n = 0;
    while (first_vld < 0 && n < 20) begin
      @(posedge ACLK); n++;
    end
    #1;
    chk("t6_valid_seen", 32'(first_vld >= 0), 32'd1);
    held = 0;
    for (int i = 0; i < 5; i++) begin
      held += int'(m_axis_tvalid && m_axis_tlast);
      @(posedge ACLK); #1;
    end
    chk("t6_held", 32'(held), 32'd5);
    chk("t6_no_done_yet", 32'(done_n), 32'd0);
    m_axis_tready = 1'b1;
    wait_done("t6");
    idle(3);
    chk_data("t6", 10'h050, 1);
    chk("t6_stable", 32'(stall_err), 32'd0);
    chk("t6_done_lat", 32'(done_cyc - beat_c[0]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
